rvga_hazard_ctl: RTL and testbench

Scoreboard-based hazard controller for the rvga in-order pipeline. It sits beside the register-fetch stage and tracks, per architectural register, how many issued-but-not-written-back instructions target it. It stalls decode and injects bubbles into the register-fetch stage whenever an instruction would read a stale register or overflow a scoreboard counter, so register-fetch never reads a value still in flight. It also merges the external memory stall and counts stall cycles for performance monitoring.

---
 rtl/rvga_hazard_ctl_pkg.sv | 17 +
 rtl/rvga_hazard_ctl_sb_cnt.sv | 50 +++++
 rtl/rvga_hazard_ctl.sv | 114 +++++++++++
 tb/tb_rvga_hazard_ctl.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvga_hazard_ctl_pkg.sv
// Shared types and sizing for the rvga register-fetch hazard controller.
package rvga_hazard_ctl_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_CNT_W    = 2;
    localparam int REG_AW       = $clog2(DEF_NUM_REGS);
    localparam int STALL_W      = 32;

    // Only the fields the hazard logic looks at; the rest of the cword is carried elsewhere.
    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regfile_load;
    } rvga_cword;

endpackage

// File: rtl/rvga_hazard_ctl_sb_cnt.sv
// One scoreboard entry: saturating up/down counter taking one increment and up to two
// decrements per cycle, clamping at zero and flagging the underflow.
module rvga_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [1:0]       dec2,
    output logic [CNT_W-1:0] cnt,
    output logic             uflow
);

    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SUM_W-1:0] up_sum;
    logic [SUM_W-1:0] dec_ext;
    logic [SUM_W-1:0] diff;

    // Increment first in a wider word so inc and dec in the same cycle cancel exactly.
    always_comb begin
        up_sum  = {2'b00, cnt_q} + {{(SUM_W-1){1'b0}}, inc};
        dec_ext = {{CNT_W{1'b0}}, dec2};
        diff    = up_sum - dec_ext;
        uflow   = 1'b0;
        cnt_d   = cnt_q;
        if (up_sum < dec_ext) begin
            uflow = 1'b1;
            cnt_d = '0;
        end else if (diff > CNT_MAX) begin
            cnt_d = CNT_MAX[CNT_W-1:0];
        end else begin
            cnt_d = diff[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rvga_hazard_ctl.sv
// Scoreboard hazard controller: stalls decode and bubbles register-fetch while a source
// register is in flight or a destination counter is full; merges ext_stall, counts stalls.
module rvga_hazard_ctl
    import rvga_hazard_ctl_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ext_stall,
    input  logic                        de_valid,
    input  rvga_cword                   de_rf_cword,
    input  logic                        wb_valid,
    input  rvga_cword                   wb_rf_cword,
    input  logic                        squash,
    input  logic [$clog2(NUM_REGS)-1:0] squash_rd,
    output logic                        pipe_stall,
    output logic                        de_hold,
    output logic                        rf_bubble,
    output logic [STALL_W-1:0]          stall_cycles,
    output logic                        sb_err
);

    localparam int SQ_W = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   cnt [NUM_REGS];
    logic [NUM_REGS-1:0] uflow;

    logic raw_rs1;
    logic raw_rs2;
    logic cap_rd;
    logic hazard;
    logic issue;
    logic retire;
    logic kill;

    logic               sb_err_q;
    logic               sb_err_d;
    logic [STALL_W-1:0] stall_cycles_q;
    logic [STALL_W-1:0] stall_cycles_d;

    logic unused_wb_fields;

    assign cnt[0]   = '0;
    assign uflow[0] = 1'b0;

    always_comb begin
        raw_rs1 = (de_rf_cword.rs1 != '0) && (cnt[de_rf_cword.rs1] != '0);
        raw_rs2 = (de_rf_cword.rs2 != '0) && (cnt[de_rf_cword.rs2] != '0);
        cap_rd  = de_rf_cword.regfile_load && (de_rf_cword.rd != '0)
                  && (cnt[de_rf_cword.rd] == CNT_MAX);
        hazard  = de_valid && (raw_rs1 || raw_rs2 || cap_rd);
    end

    assign pipe_stall = ext_stall;
    assign de_hold    = ext_stall | hazard;
    assign rf_bubble  = hazard & ~ext_stall;

    // Squash comes from EX and must be honoured even while the pipe is frozen.
    assign issue  = de_valid && !hazard && !ext_stall
                    && de_rf_cword.regfile_load && (de_rf_cword.rd != '0);
    assign retire = wb_valid && !ext_stall
                    && wb_rf_cword.regfile_load && (wb_rf_cword.rd != '0);
    assign kill   = squash && (squash_rd != '0);

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic       inc;
            logic       ret_hit;
            logic       kill_hit;
            logic [1:0] dec2;

            assign inc      = issue  && (de_rf_cword.rd == REG_AW'(gi));
            assign ret_hit  = retire && (wb_rf_cword.rd == REG_AW'(gi));
            assign kill_hit = kill   && (squash_rd == SQ_W'(gi));
            assign dec2     = {1'b0, ret_hit} + {1'b0, kill_hit};

            rvga_sb_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (inc),
                .dec2  (dec2),
                .cnt   (cnt[gi]),
                .uflow (uflow[gi])
            );
        end
    endgenerate

    always_comb begin
        sb_err_d       = sb_err_q | (|uflow);
        stall_cycles_d = stall_cycles_q + {{(STALL_W-1){1'b0}}, de_hold};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            sb_err_q       <= sb_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb_err       = sb_err_q;
    assign stall_cycles = stall_cycles_q;

    // Writeback source fields are part of the cword but irrelevant to retirement.
    assign unused_wb_fields = ^{wb_rf_cword.rs1, wb_rf_cword.rs2};

endmodule

// File: tb/tb_rvga_hazard_ctl.sv
// Self-checking bench for rvga_hazard_ctl: directed scenarios plus a randomized run,
// all checked against a per-register in-flight count model.
module tb_rvga_hazard_ctl;
    import rvga_hazard_ctl_pkg::*;

    localparam int CMAX = (1 << DEF_CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ext_stall;
    logic              de_valid;
    rvga_cword         de_rf_cword;
    logic              wb_valid;
    rvga_cword         wb_rf_cword;
    logic              squash;
    logic [REG_AW-1:0] squash_rd;
    logic              pipe_stall;
    logic              de_hold;
    logic              rf_bubble;
    logic [31:0]       stall_cycles;
    logic              sb_err;

    int          checks = 0;
    int          errors = 0;
    int          m_cnt [DEF_NUM_REGS];
    bit          m_err;
    logic [31:0] m_stall;

    always #5 clk = ~clk;

    rvga_hazard_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .ext_stall    (ext_stall),
        .de_valid     (de_valid),
        .de_rf_cword  (de_rf_cword),
        .wb_valid     (wb_valid),
        .wb_rf_cword  (wb_rf_cword),
        .squash       (squash),
        .squash_rd    (squash_rd),
        .pipe_stall   (pipe_stall),
        .de_hold      (de_hold),
        .rf_bubble    (rf_bubble),
        .stall_cycles (stall_cycles),
        .sb_err       (sb_err)
    );

    function automatic rvga_cword cw(int rs1, int rs2, int rd, bit ld);
        rvga_cword c;
        c.rs1          = REG_AW'(rs1);
        c.rs2          = REG_AW'(rs2);
        c.rd           = REG_AW'(rd);
        c.regfile_load = ld;
        return c;
    endfunction

    // A decode instruction must wait if it reads anything in flight or its target is full.
    function automatic bit m_hazard();
        if (!de_valid) return 1'b0;
        if (de_rf_cword.rs1 != 0 && m_cnt[de_rf_cword.rs1] != 0) return 1'b1;
        if (de_rf_cword.rs2 != 0 && m_cnt[de_rf_cword.rs2] != 0) return 1'b1;
        if (de_rf_cword.regfile_load && de_rf_cword.rd != 0 && m_cnt[de_rf_cword.rd] == CMAX)
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        ext_stall   = 1'b0;
        de_valid    = 1'b0;
        de_rf_cword = cw(0, 0, 0, 1'b0);
        wb_valid    = 1'b0;
        wb_rf_cword = cw(0, 0, 0, 1'b0);
        squash      = 1'b0;
        squash_rd   = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < DEF_NUM_REGS; r++) m_cnt[r] = 0;
        m_err   = 1'b0;
        m_stall = '0;
    endtask

    // Advance the model by one cycle using the inputs now applied, then clock the DUT.
    task automatic tick();
        bit h;
        h = m_hazard();
        if (ext_stall || h) m_stall = m_stall + 32'd1;
        if (de_valid && !h && !ext_stall && de_rf_cword.regfile_load && de_rf_cword.rd != 0)
            m_cnt[de_rf_cword.rd] = m_cnt[de_rf_cword.rd] + 1;
        if (wb_valid && !ext_stall && wb_rf_cword.regfile_load && wb_rf_cword.rd != 0)
            m_cnt[wb_rf_cword.rd] = m_cnt[wb_rf_cword.rd] - 1;
        if (squash && squash_rd != 0)
            m_cnt[squash_rd] = m_cnt[squash_rd] - 1;
        for (int r = 1; r < DEF_NUM_REGS; r++) begin
            if (m_cnt[r] < 0) begin
                m_err    = 1'b1;
                m_cnt[r] = 0;
            end
            if (m_cnt[r] > CMAX) m_cnt[r] = CMAX;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({pipe_stall, de_hold, rf_bubble, sb_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {pipe_stall, de_hold, rf_bubble, sb_err});
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({de_hold, stall_cycles} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_idle_cycle: got hold=%b stalls=%0d expected 0/0", de_hold, stall_cycles);
        end
        $display("test_reset done");
    endtask

    task automatic test_raw();
        idle();
        de_valid    = 1'b1;
        de_rf_cword = cw(0, 0, 5, 1'b1);
        #1;
        checks++;
        if (de_hold !== 1'b0) begin
            errors++;
            $display("FAIL raw_writer_issue: got hold=%b expected 0", de_hold);
        end
        tick();
        de_rf_cword = cw(5, 0, 0, 1'b0);
        wb_rf_cword = cw(0, 0, 5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wb_valid = (i == 2);
            #1;
            checks++;
            if ({de_hold, rf_bubble} !== 2'b11) begin
                errors++;
                $display("FAIL raw_stall_cycle%0d: got hold/bubble=%b expected 11", i, {de_hold, rf_bubble});
            end
            tick();
        end
        wb_valid = 1'b0;
        #1;
        checks++;
        if ({de_hold, rf_bubble} !== 2'b00) begin
            errors++;
            $display("FAIL raw_dep_issue: got hold/bubble=%b expected 00", {de_hold, rf_bubble});
        end
        tick();
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL raw_stall_count: got %0d expected 3", stall_cycles);
        end
        idle();
        $display("test_raw done");
    endtask

    task automatic test_x0();
        idle();
        de_valid    = 1'b1;
        de_rf_cword = cw(0, 0, 0, 1'b1);
        wb_valid    = 1'b1;
        wb_rf_cword = cw(0, 0, 0, 1'b1);
        squash      = 1'b1;
        squash_rd   = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (de_hold !== 1'b0) begin
                errors++;
                $display("FAIL x0_no_hazard%0d: got hold=%b expected 0", i, de_hold);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (sb_err !== 1'b0) begin
            errors++;
            $display("FAIL x0_no_err: got sb_err=%b expected 0", sb_err);
        end
        $display("test_x0 done");
    endtask

    task automatic test_same_cycle();
        idle();
        de_valid    = 1'b1;
        de_rf_cword = cw(0, 0, 7, 1'b1);
        tick();
        tick();
        wb_valid    = 1'b1;
        wb_rf_cword = cw(0, 0, 7, 1'b1);
        squash      = 1'b1;
        squash_rd   = 7;
        #1;
        checks++;
        if (de_hold !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_issue: got hold=%b expected 0", de_hold);
        end
        tick();
        idle();
        de_valid    = 1'b1;
        de_rf_cword = cw(7, 0, 0, 1'b0);
        #1;
        checks++;
        if (de_hold !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_nonzero: got hold=%b expected 1", de_hold);
        end
        de_valid    = 1'b0;
        wb_valid    = 1'b1;
        wb_rf_cword = cw(0, 0, 7, 1'b1);
        tick();
        wb_valid = 1'b0;
        de_valid = 1'b1;
        #1;
        checks++;
        if (de_hold !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_cnt_one: got hold=%b expected 0", de_hold);
        end
        de_rf_cword = cw(0, 0, 7, 1'b1);
        tick();
        wb_valid = 1'b1;
        tick();
        wb_valid    = 1'b0;
        de_rf_cword = cw(7, 0, 0, 1'b0);
        #1;
        checks++;
        if (de_hold !== 1'b1) begin
            errors++;
            $display("FAIL inc_dec_cancel_nonzero: got hold=%b expected 1", de_hold);
        end
        de_valid = 1'b0;
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        de_valid = 1'b1;
        #1;
        checks++;
        if ({de_hold, sb_err} !== 2'b00) begin
            errors++;
            $display("FAIL inc_dec_cancel_one: got hold/err=%b expected 00", {de_hold, sb_err});
        end
        idle();
        $display("test_same_cycle done");
    endtask

    task automatic test_capacity();
        idle();
        de_valid    = 1'b1;
        de_rf_cword = cw(0, 0, 3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (de_hold !== 1'b0) begin
                errors++;
                $display("FAIL cap_fill%0d: got hold=%b expected 0", i, de_hold);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({de_hold, rf_bubble} !== 2'b11) begin
                errors++;
                $display("FAIL cap_hold%0d: got hold/bubble=%b expected 11", i, {de_hold, rf_bubble});
            end
            tick();
        end
        wb_valid    = 1'b1;
        wb_rf_cword = cw(0, 0, 3, 1'b1);
        #1;
        checks++;
        if (de_hold !== 1'b1) begin
            errors++;
            $display("FAIL cap_hold_at_retire: got hold=%b expected 1", de_hold);
        end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if (de_hold !== 1'b0) begin
            errors++;
            $display("FAIL cap_release: got hold=%b expected 0", de_hold);
        end
        tick();
        de_valid = 1'b0;
        wb_valid = 1'b1;
        repeat (3) tick();
        wb_valid    = 1'b0;
        de_valid    = 1'b1;
        de_rf_cword = cw(3, 3, 0, 1'b0);
        #1;
        checks++;
        if ({de_hold, sb_err} !== 2'b00) begin
            errors++;
            $display("FAIL cap_drained: got hold/err=%b expected 00", {de_hold, sb_err});
        end
        idle();
        $display("test_capacity done");
    endtask

    task automatic test_ext_stall();
        logic [31:0] s0;
        idle();
        de_valid    = 1'b1;
        de_rf_cword = cw(0, 0, 10, 1'b1);
        tick();
        de_rf_cword = cw(0, 10, 0, 1'b0);
        ext_stall   = 1'b1;
        wb_valid    = 1'b1;
        wb_rf_cword = cw(0, 0, 10, 1'b1);
        s0 = m_stall;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({pipe_stall, de_hold, rf_bubble} !== 3'b110) begin
                errors++;
                $display("FAIL ext_stall_outputs%0d: got %b expected 110", i, {pipe_stall, de_hold, rf_bubble});
            end
            tick();
        end
        checks++;
        if (stall_cycles !== s0 + 32'd4) begin
            errors++;
            $display("FAIL ext_stall_count: got %0d expected %0d", stall_cycles, s0 + 32'd4);
        end
        ext_stall = 1'b0;
        wb_valid  = 1'b0;
        #1;
        checks++;
        if ({pipe_stall, de_hold, rf_bubble} !== 3'b011) begin
            errors++;
            $display("FAIL ext_stall_cnt_frozen: got %b expected 011", {pipe_stall, de_hold, rf_bubble});
        end
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if (de_hold !== 1'b0) begin
            errors++;
            $display("FAIL ext_stall_after_retire: got hold=%b expected 0", de_hold);
        end
        de_rf_cword = cw(0, 0, 11, 1'b1);
        tick();
        de_valid  = 1'b0;
        ext_stall = 1'b1;
        squash    = 1'b1;
        squash_rd = 11;
        tick();
        squash      = 1'b0;
        ext_stall   = 1'b0;
        de_valid    = 1'b1;
        de_rf_cword = cw(11, 0, 0, 1'b0);
        #1;
        checks++;
        if (de_hold !== 1'b0) begin
            errors++;
            $display("FAIL squash_in_stall: got hold=%b expected 0", de_hold);
        end
        idle();
        $display("test_ext_stall done");
    endtask

    task automatic test_underflow_reset();
        idle();
        wb_valid    = 1'b1;
        wb_rf_cword = cw(0, 0, 9, 1'b1);
        #1;
        checks++;
        if (sb_err !== 1'b0) begin
            errors++;
            $display("FAIL uflow_before: got sb_err=%b expected 0", sb_err);
        end
        tick();
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sb_err !== 1'b1) begin
                errors++;
                $display("FAIL uflow_sticky%0d: got sb_err=%b expected 1", i, sb_err);
            end
            tick();
        end
        de_valid    = 1'b1;
        de_rf_cword = cw(9, 0, 0, 1'b0);
        #1;
        checks++;
        if (de_hold !== 1'b0) begin
            errors++;
            $display("FAIL uflow_clamp: got hold=%b expected 0", de_hold);
        end
        de_rf_cword = cw(0, 0, 4, 1'b1);
        tick();
        de_rf_cword = cw(4, 0, 0, 1'b0);
        ext_stall   = 1'b1;
        tick();
        tick();
        #2;
        checks++;
        if (de_hold !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_hold: got hold=%b expected 1", de_hold);
        end
        ext_stall = 1'b0;
        rst       = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({pipe_stall, de_hold, rf_bubble, sb_err, stall_cycles} !== {4'b0000, 32'd0}) begin
            errors++;
            $display("FAIL async_reset: got flags=%b stalls=%0d expected 0000/0",
                     {pipe_stall, de_hold, rf_bubble, sb_err}, stall_cycles);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        $display("test_underflow_reset done");
    endtask

    task automatic test_random();
        int  r;
        bit  exp_h;
        for (int n = 0; n < 500; n++) begin
            ext_stall   = ($urandom_range(0, 9) == 0);
            de_valid    = ($urandom_range(0, 3) != 0);
            de_rf_cword = cw($urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            r = $urandom_range(0, 7);
            wb_valid    = (m_cnt[r] > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            wb_rf_cword = cw(0, 0, r, 1'b1);
            squash      = ($urandom_range(0, 15) == 0);
            squash_rd   = REG_AW'($urandom_range(0, 7));
            #1;
            exp_h = m_hazard();
            checks++;
            if ({pipe_stall, de_hold, rf_bubble} !== {ext_stall, ext_stall | exp_h, exp_h & ~ext_stall}) begin
                errors++;
                $display("FAIL rand_outputs%0d: got %b expected %b", n, {pipe_stall, de_hold, rf_bubble},
                         {ext_stall, ext_stall | exp_h, exp_h & ~ext_stall});
            end
            checks++;
            if ({sb_err, stall_cycles} !== {m_err, m_stall}) begin
                errors++;
                $display("FAIL rand_state%0d: got err=%b stalls=%0d expected err=%b stalls=%0d",
                         n, sb_err, stall_cycles, m_err, m_stall);
            end
            tick();
        end
        idle();
        $display("test_random done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_raw();
        test_x0();
        test_same_cycle();
        test_capacity();
        test_ext_stall();
        test_underflow_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
